inst_fetch_unit: RTL and testbench

Instruction fetch front-end for the RV32I core. It owns the program counter and drives the read port of the instruction memory, which is synchronous with one-cycle read latency and holds its output when not enabled. Fetched words go through a 2-entry buffer to decode under a valid/ready handshake. It handles branch/jump redirects, discards stale in-flight reads, and reports fetch faults for misaligned or out-of-range PCs.

---
 rtl/inst_fetch_unit.sv | 137 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// RV32I instruction fetch: PC ownership, one-cycle-latency imem reads, 2-entry
// decode buffer with valid/ready, redirect handling and fetch-fault reporting.
module inst_fetch_unit #(
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned INST_DEPTH = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          fetch_en,
  input  logic                          redirect,
  input  logic [31:0]                   redirect_pc,
  output logic                          mem_rd_en,
  output logic [$clog2(INST_DEPTH)-1:0] mem_rd_addr,
  input  logic [INST_WIDTH-1:0]         mem_instruction,
  output logic                          inst_valid,
  input  logic                          inst_ready,
  output logic [INST_WIDTH-1:0]         inst,
  output logic [31:0]                   inst_pc,
  output logic                          inst_err
);

  localparam int unsigned AW = $clog2(INST_DEPTH);
  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FAULT = 1'b1;

  logic [31:0]           pc, pc_nxt;
  logic [31:0]           resp_pc, resp_pc_nxt;
  logic                  resp_v, resp_v_nxt;
  logic [1:0]            count, count_nxt;
  logic [0:0]            mode, mode_nxt;
  logic [INST_WIDTH-1:0] b0_inst, b0_inst_nxt, b1_inst, b1_inst_nxt;
  logic [31:0]           b0_pc, b0_pc_nxt, b1_pc, b1_pc_nxt;

  logic pc_bad, show_fault, pop, push, room;

  // Fault, handshake and issue qualification
  always_comb begin
    pc_bad     = (pc[1:0] != 2'b00) || (pc[31:2] >= 30'(INST_DEPTH));
    show_fault = (mode == FAULT) && (count == 2'd0) && !resp_v;
    pop        = (count != 2'd0) && inst_ready;
    push       = resp_v && !redirect;
    room       = (3'(count) + 3'(resp_v) - 3'(pop)) < 3'd2;
    mem_rd_en  = rst_n && fetch_en && !redirect && (mode == RUN) && !pc_bad && room;
  end

  assign mem_rd_addr = pc[AW+1:2];

  // Buffer head, or the held fault entry once everything older has drained
  always_comb begin
    inst_valid = (count != 2'd0) || show_fault;
    inst_err   = show_fault;
    inst       = (count != 2'd0) ? b0_inst : '0;
    inst_pc    = (count != 2'd0) ? b0_pc : (show_fault ? pc : 32'h0);
  end

  always_comb begin
    pc_nxt      = pc;
    resp_pc_nxt = resp_pc;
    resp_v_nxt  = 1'b0;
    count_nxt   = count;
    mode_nxt    = mode;
    b0_inst_nxt = b0_inst;
    b0_pc_nxt   = b0_pc;
    b1_inst_nxt = b1_inst;
    b1_pc_nxt   = b1_pc;
    if (redirect) begin
      // Flushes buffer and drops any response landing this cycle
      pc_nxt    = redirect_pc;
      count_nxt = 2'd0;
      mode_nxt  = RUN;
    end else begin
      resp_v_nxt = mem_rd_en;
      if (mem_rd_en) begin
        pc_nxt      = pc + 32'd4;
        resp_pc_nxt = pc;
      end
      if ((mode == RUN) && pc_bad) begin
        mode_nxt = FAULT;
      end
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            b0_inst_nxt = mem_instruction;
            b0_pc_nxt   = resp_pc;
          end else begin
            b1_inst_nxt = mem_instruction;
            b1_pc_nxt   = resp_pc;
          end
          count_nxt = count + 2'd1;
        end
        2'b01: begin
          b0_inst_nxt = b1_inst;
          b0_pc_nxt   = b1_pc;
          count_nxt   = count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            b0_inst_nxt = mem_instruction;
            b0_pc_nxt   = resp_pc;
          end else begin
            b0_inst_nxt = b1_inst;
            b0_pc_nxt   = b1_pc;
            b1_inst_nxt = mem_instruction;
            b1_pc_nxt   = resp_pc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      resp_pc <= 32'h0;
      resp_v  <= 1'b0;
      count   <= 2'd0;
      mode    <= RUN;
      b0_inst <= '0;
      b0_pc   <= 32'h0;
      b1_inst <= '0;
      b1_pc   <= 32'h0;
    end else begin
      pc      <= pc_nxt;
      resp_pc <= resp_pc_nxt;
      resp_v  <= resp_v_nxt;
      count   <= count_nxt;
      mode    <= mode_nxt;
      b0_inst <= b0_inst_nxt;
      b0_pc   <= b0_pc_nxt;
      b1_inst <= b1_inst_nxt;
      b1_pc   <= b1_pc_nxt;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: queue-based fetch model checked every cycle,
// directed scenarios pinned with literal expectations, then random traffic.
module tb_inst_fetch_unit;

  localparam int unsigned IW     = 32;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam logic [31:0] RST_PC = 32'h0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          fetch_en = 1'b0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = 32'h0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [IW-1:0] mem_instruction = '0;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [IW-1:0] inst;
  logic [31:0]   inst_pc;
  logic          inst_err;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_rpc = 32'h0;
  bit          m_rv = 1'b0;
  bit          m_fault = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  inst_fetch_unit #(
    .INST_WIDTH(IW),
    .INST_DEPTH(DEPTH),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .mem_rd_en      (mem_rd_en),
    .mem_rd_addr    (mem_rd_addr),
    .mem_instruction(mem_instruction),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_err       (inst_err)
  );

  always #5 clk = ~clk;

  // Synchronous memory, word k holds 0x1000_0000 + k, output held when idle
  always @(posedge clk) begin
    if (mem_rd_en) mem_instruction <= 32'h1000_0000 + 32'(mem_rd_addr);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc    = RST_PC;
    m_rv    = 1'b0;
    m_fault = 1'b0;
  endtask

  // One clock: drive at negedge, compare against model, advance model over the edge
  task automatic cycle(input logic r, input logic [31:0] rpc, input logic fe, input logic rdy);
    int   cnt;
    logic show, pop, bad, en;
    ent_t h, e;
    @(negedge clk);
    redirect    = r;
    redirect_pc = rpc;
    fetch_en    = fe;
    inst_ready  = rdy;
    #1;
    cnt  = q.size();
    show = m_fault && (cnt == 0) && !m_rv;
    pop  = (cnt > 0) && rdy;
    bad  = (m_pc[1:0] != 2'b00) || ((m_pc >> 2) >= 32'(DEPTH));
    en   = fe && !r && !m_fault && !bad && ((cnt + int'(m_rv) - int'(pop)) < 2);
    if (cnt > 0) h = q[0];
    else begin
      h.ins = 32'h0;
      h.pc  = show ? m_pc : 32'h0;
    end
    chk1("valid", inst_valid, (cnt > 0) || show);
    chk1("err", inst_err, show);
    chk("inst", inst, h.ins);
    chk("inst_pc", inst_pc, h.pc);
    chk1("rd_en", mem_rd_en, en);
    chk("rd_addr", 32'(mem_rd_addr), (m_pc >> 2) % 32'(DEPTH));
    if (r) begin
      q.delete();
      m_rv    = 1'b0;
      m_pc    = rpc;
      m_fault = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (m_rv) begin
        e.ins = 32'h1000_0000 + (m_rpc >> 2);
        e.pc  = m_rpc;
        q.push_back(e);
      end
      if (bad) m_fault = 1'b1;
      m_rv  = en;
      m_rpc = m_pc;
      if (en) m_pc = m_pc + 32'd4;
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk1("rst_valid", inst_valid, 1'b0);
    chk1("rst_err", inst_err, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk1("rst_rd_en", mem_rd_en, 1'b0);
    chk("rst_rd_addr", 32'(mem_rd_addr), 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();

    // Stream from reset with decode always ready
    for (int k = 0; k < 7; k++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      if (k == 0) chk1("first_rd_en", mem_rd_en, 1'b1);
      if (k == 1) chk1("not_valid_yet", inst_valid, 1'b0);
      if (k >= 2) begin
        chk("stream_pc", inst_pc, 32'(4 * (k - 2)));
        chk("stream_inst", inst, 32'h1000_0000 + 32'(k - 2));
      end
    end

    // Backpressure: head held, reads stop once the buffer is committed full
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      chk("bp_head", inst_pc, 32'h14);
      chk1("bp_rd_en", mem_rd_en, 1'b0);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk("bp_rel0", inst_pc, 32'h14);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk("bp_rel1", inst_pc, 32'h18);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk("bp_rel2", inst_pc, 32'h1C);

    // Redirect while a read is in flight
    cycle(1'b1, 32'h40, 1'b1, 1'b1);
    chk1("redir_no_issue", mem_rd_en, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk1("redir_issue", mem_rd_en, 1'b1);
    chk("redir_addr", 32'(mem_rd_addr), 32'h10);
    chk1("redir_flushed", inst_valid, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk1("redir_stale_dropped", inst_valid, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk("redir_pc", inst_pc, 32'h40);
    chk("redir_inst", inst, 32'h1000_0010);

    // Misaligned target: fault entry held through ready until redirected away
    cycle(1'b1, 32'h42, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk1("mis_no_issue", mem_rd_en, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      chk1("mis_valid", inst_valid, 1'b1);
      chk1("mis_err", inst_err, 1'b1);
      chk("mis_inst", inst, 32'h0);
      chk("mis_pc", inst_pc, 32'h42);
    end
    cycle(1'b1, 32'h0, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk1("mis_resume", mem_rd_en, 1'b1);
    chk1("mis_cleared", inst_err, 1'b0);

    // Sequential run-off past the last word
    cycle(1'b1, 32'h70, 1'b1, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      if (k >= 3 && k <= 6) chk("runoff_pc", inst_pc, 32'h70 + 32'(4 * (k - 3)));
      if (k == 6) chk1("runoff_last_ok", inst_err, 1'b0);
      if (k == 7) begin
        chk1("runoff_err", inst_err, 1'b1);
        chk1("runoff_valid", inst_valid, 1'b1);
        chk("runoff_fpc", inst_pc, 32'h80);
      end
    end

    // Async reset with a full buffer
    cycle(1'b1, 32'h0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk1("full_valid", inst_valid, 1'b1);
    chk1("full_rd_en", mem_rd_en, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk1("arst_valid", inst_valid, 1'b0);
    chk1("arst_err", inst_err, 1'b0);
    chk("arst_inst", inst, 32'h0);
    chk("arst_inst_pc", inst_pc, 32'h0);
    chk1("arst_rd_en", mem_rd_en, 1'b0);
    chk("arst_rd_addr", 32'(mem_rd_addr), 32'h0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk1("restart_rd_en", mem_rd_en, 1'b1);
    chk("restart_addr", 32'(mem_rd_addr), 32'h0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk("restart_pc", inst_pc, 32'h0);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      logic        r;
      logic [31:0] t;
      r = ($urandom_range(15) == 0);
      case ($urandom_range(7))
        0:       t = (32'($urandom_range(DEPTH - 1)) << 2) + 32'($urandom_range(3, 1));
        1:       t = 32'h80 + (32'($urandom_range(63)) << 2);
        2:       t = 32'hFFFF_FFFC;
        default: t = 32'($urandom_range(DEPTH - 1)) << 2;
      endcase
      cycle(r, t, ($urandom_range(7) != 0), ($urandom_range(3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
